// File: rtl/axi2ahb_rd_sched_pkg.sv
// Shared encodings for the AXI-to-AHB read sequencer: AHB transfer/burst
// codes and the address-side FSM states.
package axi2ahb_rd_sched_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  // Transfer type for an address beat: error bursts never touch the bus,
  // otherwise NONSEQ starts a burst (or re-issues at a 1 KB boundary).
  function automatic logic [1:0] beat_htrans(input logic err, input logic nonseq);
    if (err)         return HTRANS_IDLE;
    else if (nonseq) return HTRANS_NONSEQ;
    else             return HTRANS_SEQ;
  endfunction

endpackage

// File: rtl/axi2ahb_rd_beat_cnt.sv
// Beat counter for one burst: cleared on load, bumped on inc, and flags
// the terminal beat when the count equals the burst's beats-1 field.
module axi2ahb_rd_beat_cnt #(
  parameter int LEN_BITS = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                inc,
  input  logic [LEN_BITS-1:0] len,
  output logic [LEN_BITS-1:0] cnt,
  output logic                term
);

  // Count register; load wins over inc so a new burst always starts at 0.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= '0;
    else if (inc)  cnt <= cnt + 1'b1;
  end

  assign term = (cnt == len);

endmodule

// File: rtl/axi2ahb_rd_sched.sv
// AHB-side read sequencer: takes one AXI read command at a time, plays it
// out as an AHB SINGLE/INCR read burst, and tracks data phases for the
// read data FIFO (phase valid, last beat, owning ID and error flag).
module axi2ahb_rd_sched
  import axi2ahb_rd_sched_pkg::*;
#(
  parameter int ADDR_BITS = 32,
  parameter int ID_BITS   = 4,
  parameter int LEN_BITS  = 4,
  parameter int KB_BOUND  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [LEN_BITS-1:0]  cmd_len,
  input  logic [1:0]           cmd_size,
  input  logic [ID_BITS-1:0]   cmd_id_in,
  input  logic                 cmd_err_in,
  input  logic                 rdata_ready,
  output logic [ADDR_BITS-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HSIZE,
  output logic [2:0]           HBURST,
  output logic                 HWRITE,
  input  logic                 HREADY,
  input  logic                 HRESP,
  output logic                 rdata_phase,
  output logic                 data_last,
  output logic [ID_BITS-1:0]   cmd_id,
  output logic                 cmd_err
);

  state_t state, state_nxt;

  // Fields of the burst currently in its address phases.
  logic [LEN_BITS-1:0] a_len;
  logic [ID_BITS-1:0]  a_id;
  logic                a_err;
  // Length of the burst currently in its data phases.
  logic [LEN_BITS-1:0] d_len;

  logic [LEN_BITS-1:0] addr_cnt, data_cnt;
  logic                addr_term, data_term;
  logic                addr_beat, last_addr_beat, first_beat, data_done, accept;
  logic [ADDR_BITS-1:0] haddr_nxt;

  // HRESP is carried to the FIFO elsewhere; errors never alter sequencing here.
  logic hresp_unused;
  assign hresp_unused = HRESP;

  assign HWRITE         = 1'b0;
  assign addr_beat      = (state == ST_ADDR) && HREADY;
  assign last_addr_beat = addr_beat && addr_term;
  assign first_beat     = addr_beat && (addr_cnt == '0);
  assign data_done      = rdata_phase && HREADY;
  // Reset is folded in so cmd_ready reads 0 while reset is held.
  assign cmd_ready      = !reset && rdata_ready && ((state == ST_IDLE) || last_addr_beat);
  assign accept         = cmd_valid && cmd_ready;
  assign haddr_nxt      = HADDR + (ADDR_BITS'(1) << HSIZE[1:0]);
  assign data_last      = rdata_phase && data_term;

  axi2ahb_rd_beat_cnt #(.LEN_BITS(LEN_BITS)) u_addr_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .inc   (addr_beat && !addr_term),
    .len   (a_len),
    .cnt   (addr_cnt),
    .term  (addr_term)
  );

  axi2ahb_rd_beat_cnt #(.LEN_BITS(LEN_BITS)) u_data_cnt (
    .clk   (clk),
    .reset (reset),
    .load  (first_beat),
    .inc   (data_done),
    .len   (d_len),
    .cnt   (data_cnt),
    .term  (data_term)
  );

  // FSM state register.
  // NOTE: asynchronous reset sits in the sensitivity list so outputs clear without a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: IDLE -> ADDR on accept; ADDR stays on back-to-back accept or
  // drains after its last beat; DRAIN returns once the final data phase completes.
  // NOTE: the default assignment first keeps this purely combinational (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ADDR;
      ST_ADDR:  if (last_addr_beat) state_nxt = accept ? ST_ADDR : ST_DRAIN;
      ST_DRAIN: if (data_done && data_term) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Address-phase outputs: launch on accept, advance on HREADY, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HADDR  <= '0;
      HTRANS <= HTRANS_IDLE;
      HSIZE  <= '0;
      HBURST <= HBURST_SINGLE;
      a_len  <= '0;
      a_id   <= '0;
      a_err  <= 1'b0;
    end else if (accept) begin
      HADDR  <= cmd_addr;
      HTRANS <= beat_htrans(cmd_err_in, 1'b1);
      HSIZE  <= {1'b0, cmd_size};
      HBURST <= (cmd_len == '0) ? HBURST_SINGLE : HBURST_INCR;
      a_len  <= cmd_len;
      a_id   <= cmd_id_in;
      a_err  <= cmd_err_in;
    end else if (addr_beat) begin
      if (addr_term) begin
        HTRANS <= HTRANS_IDLE;
      end else begin
        HADDR  <= haddr_nxt;
        HTRANS <= beat_htrans(a_err, haddr_nxt[KB_BOUND-1:0] == '0);
      end
    end
  end

  // Data-phase tracking: a phase opens after each accepted address beat and
  // takes ownership (ID, error, length) from the burst's first beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_phase <= 1'b0;
      d_len       <= '0;
      cmd_id      <= '0;
      cmd_err     <= 1'b0;
    end else begin
      if (addr_beat)      rdata_phase <= 1'b1;
      else if (data_done) rdata_phase <= 1'b0;
      if (first_beat) begin
        d_len   <= a_len;
        cmd_id  <= a_id;
        cmd_err <= a_err;
      end
    end
  end

endmodule

// File: doc/axi2ahb_rd_sched.md
Name: axi2ahb_rd_sched

Overview:
- AHB-side read sequencer of the AXI-to-AHB bridge. Sits between the AXI read-command queue and the read data FIFO.
- Accepts one AXI read command at a time and converts it into an AHB INCR/SINGLE read burst on HADDR/HTRANS.
- Tracks AHB address and data phases and drives rdata_phase, data_last, cmd_id and cmd_err to the read data FIFO.
- Throttled by rdata_ready, the FIFO's burst-credit signal.

Parameters:
- ADDR_BITS, 32, AHB/AXI address width
- ID_BITS, 4, AXI ID width
- LEN_BITS, 4, AXI burst length field width (beats-1)
- KB_BOUND, 10, log2 of AHB burst boundary (1 KB)

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- cmd_valid  in  1  read command available
- cmd_ready  out  1  command accepted this cycle
- cmd_addr  in  ADDR_BITS  start address (aligned to size)
- cmd_len  in  LEN_BITS  beats-1
- cmd_size  in  2  bytes-per-beat = 1<<cmd_size
- cmd_id_in  in  ID_BITS  AXI ARID
- cmd_err_in  in  1  decode error, no real AHB access
- rdata_ready  in  1  FIFO can take another burst
- HADDR  out  ADDR_BITS  AHB address
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11
- HSIZE  out  3  {1'b0,cmd_size}
- HBURST  out  3  SINGLE=000 when len==0, else INCR=001
- HWRITE  out  1  constant 0
- HREADY  in  1  AHB ready
- HRESP  in  1  AHB error; informational only, passed through by the FIFO
- rdata_phase  out  1  AHB data phase of this read is active
- data_last  out  1  current data phase is the final beat
- cmd_id  out  ID_BITS  ID of the burst in data phase
- cmd_err  out  1  error flag of the burst in data phase

Behaviour:
- Reset is asynchronous, active-high; clock is clk. All outputs reset to 0: HTRANS=IDLE, HADDR=0, rdata_phase=0, data_last=0, cmd_ready=0. Reset mid-burst abandons the burst; no partial state survives.
- cmd_ready = (state==IDLE | last address beat being accepted this cycle) & rdata_ready. This is combinational.
- Accept occurs when cmd_valid & cmd_ready. Fields are latched on accept. HTRANS=NONSEQ with HADDR=cmd_addr appears on the next cycle; it is a registered output.
- State ADDR: an address phase is on the bus and advances only when HREADY=1.
  - On advance, addr_cnt++ and HADDR += (1<<size).
  - HTRANS is SEQ, except NONSEQ when the new HADDR[KB_BOUND-1:0]==0 (1 KB re-issue).
  - After the beat where addr_cnt==len is accepted: next command if accepted (back-to-back NONSEQ), else HTRANS=IDLE and state DRAIN.
  - HADDR, HTRANS, HSIZE and HBURST are held stable while HREADY=0.
- cmd_err_in=1: the sequencer runs the same beat count but drives HTRANS=IDLE for every beat. Beats still advance on HREADY, and rdata_phase is still asserted, so the FIFO logs len+1 error beats.
- rdata_phase is set the cycle after an address beat is accepted (HREADY=1 with an active address phase). It clears after a data phase completes with HREADY=1 and no new address beat was accepted in the same cycle.
- data_cnt increments on rdata_phase & HREADY.
- data_last = rdata_phase & (data_cnt==len of the burst in data phase).
- cmd_id and cmd_err are registered per data phase and follow the burst owning that phase. This covers back-to-back overlap, where the new burst's NONSEQ overlaps the old burst's last data phase.
- State DRAIN: wait for the last data phase with HREADY=1, then go to IDLE.
- HRESP=1: no abort and no retry. The sequence continues; the two-cycle ERROR response is absorbed as an HREADY=0 then HREADY=1 data phase.
- Width rules:
  - addr_cnt and data_cnt are LEN_BITS wide.
  - HADDR increments are ADDR_BITS wide with natural wrap at 2^ADDR_BITS. AXI guarantees bursts never cross 4 KB.

Decomposition:
- Shared package constants: HTRANS_IDLE/NONSEQ/SEQ, HBURST_SINGLE/INCR, and the FSM state encoding IDLE/ADDR/DRAIN.
- One natural sub-module: axi2ahb_rd_beat_cnt, a LEN_BITS beat counter with load, inc and terminal-compare. It is instantiated twice, once for the address phase and once for the data phase.

Test Plan:
- Single beat: len=0, size=2, addr=0x100, HREADY=1 → NONSEQ/SINGLE at 0x100 one cycle after accept. rdata_phase and data_last pulse the following cycle, then IDLE.
- 4-beat INCR: addr=0x10, len=3, size=2, with HREADY=0 for 2 cycles on beat 2 → HADDR sequence 0x10, 0x14, 0x18, 0x1C held during the wait; NONSEQ, SEQ, SEQ, SEQ; data_last on the 4th data phase only.
- 1 KB crossing: addr=0x3F8, len=3, size=2 → HADDR 0x3F8, 0x3FC, 0x400, 0x404 with HTRANS NONSEQ, SEQ, NONSEQ, SEQ.
- Back-to-back: two commands with rdata_ready=1 → second NONSEQ in the same cycle as the first burst's last data phase. cmd_id switches exactly at the second burst's first data phase.
- Credit stall and error: rdata_ready=0 holds cmd_ready=0 with no HTRANS activity. cmd_err_in=1 with len=1 → HTRANS stays IDLE, rdata_phase high 2 cycles, cmd_err=1. An HRESP ERROR beat does not shorten the burst.
- Reset mid-burst in ADDR state → all outputs 0 at once. The next command starts cleanly with a NONSEQ.
